multiplier_datapath_taint_track: RTL and testbench
==================================================

// Module: multiplier_datapath_taint_track
// PURPOSE
//   Datapath half of the sequential shift-add multiplier with bitwise taint tracking.
//   Executes the mdld/mrld/rsclear/rsload/rsshr strobes issued by the multiplier control FSM.
//   Returns multiplierReg (and its taint) to that FSM.
//   Presents the 2*WIDTH-bit product; every stored bit carries a shadow taint bit.
// PARAMETERS
//   WIDTH  4  operand width; product is 2*WIDTH bits
// PORTS
//   clk              in   1        clock; all state updates on posedge
//   rst              in   1        reset, synchronous, active-high
//   multiplicand_in  in   WIDTH    operand A
//   multiplicand_in_t in  WIDTH    taint of operand A
//   multiplier_in    in   WIDTH    operand B
//   multiplier_in_t  in   WIDTH    taint of operand B
//   mdld / mdld_t    in   1 / 1    load multiplicand reg (MD) / its taint
//   mrld / mrld_t    in   1 / 1    load multiplier reg (MR) / its taint
//   rsclear/rsclear_t in  1 / 1    clear result/sum reg (RS) / its taint
//   rsload / rsload_t in  1 / 1    add MD into RS upper half / its taint
//   rsshr / rsshr_t  in   1 / 1    shift RS right one bit / its taint
//   multiplierReg    out  WIDTH    MR contents, to controller
//   multiplierReg_t  out  WIDTH    MR taint
//   product          out  2*WIDTH  RS[2W-1:0]
//   product_t        out  2*WIDTH  RS_t[2W-1:0]
// BEHAVIOUR
//   - State: MD[W], MR[W], RS[2W+1] (bit 2W = carry), each with same-width shadow _t reg.
//   - rst=1 at posedge: all value and taint regs <= 0, overriding all strobes.
//     Outputs are combinational from regs, so they read 0 the cycle after reset.
//   - Reset mid-operation discards the partial product; no residual taint.
//   - MD/MR: if mdld, MD <= multiplicand_in and MD_t <= multiplicand_in_t (same for mrld/MR).
//     Else hold value. MR never shifts.
//   - Control taint: if X_t=1, the target's taint reg <= all-ones that edge, whether X is 0 or 1.
//     Value reg still follows X.
//   - RS priority per edge: rsclear > rsload > rsshr; lower-priority strobes are ignored.
//   - rsclear: RS <= 0; RS_t <= {2W+1{rsclear_t}}.
//   - rsload: RS[2W:W] <= {1'b0,RS[2W-1:W]} + {1'b0,MD} (W+1-bit sum); RS[W-1:0] held.
//     Sum taint m = RS_t[2W-1:W] | MD_t, carry-smeared: sum bit i tainted iff any m[j], j<=i.
//     Sum bit W tainted iff any m bit set.
//     Low-half taint held. If rsload_t: RS_t[2W:W] <= all-ones (low half held).
//   - rsshr: RS <= RS >> 1 (zero fill); RS_t <= RS_t >> 1 (zero fill).
//     If rsshr_t: RS_t <= all-ones.
//   - A control taint with no strobe asserted still applies its all-ones rule above.
//   - Arithmetic: after rsclear, then W (optional rsload, rsshr) pairs,
//     product = MD*MR exactly, with no overflow (RS[2W]=0).
//   - Latency: product final one cycle after the last rsshr edge.
//     Stable until the next rsclear/rsload/rsshr.
// TESTING
//   1 W=4, rst; drive controller sequence for md=13, mr=11, all taints 0
//     -> product=8'h8F, product_t=0.
//   2 md=15, mr=15 (max) -> product=8'hE1; RS[8] carry used mid-run and 0 at end.
//   3 md=13, md_t=4'b0001, mr=4'b0001, other taints 0
//     -> product=8'h0D, product_t=8'b0001_1111.
//   4 as test 1, with rsshr_t=1 on one shift -> product_t=8'hFF; value still 8'h8F.
//   5 rsload_t=1 with rsload=0 (MR bit=0)
//     -> RS_t[8:4] all-ones that edge; RS value unchanged.
//   6 rst asserted mid-run (after 2 loads), with rsclear+rsload same cycle
//     -> all regs 0 next cycle; then clear wins and RS=0.

Source files
------------

// File: rtl/multiplier_datapath_taint_track_if.sv
// multiplier_datapath_taint_track_if: operand, strobe and result bundle between controller and datapath
interface multiplier_datapath_taint_track_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   multiplicand_in;
    logic [WIDTH-1:0]   multiplicand_in_t;
    logic [WIDTH-1:0]   multiplier_in;
    logic [WIDTH-1:0]   multiplier_in_t;
    logic               mdld;
    logic               mdld_t;
    logic               mrld;
    logic               mrld_t;
    logic               rsclear;
    logic               rsclear_t;
    logic               rsload;
    logic               rsload_t;
    logic               rsshr;
    logic               rsshr_t;
    logic [WIDTH-1:0]   multiplierReg;
    logic [WIDTH-1:0]   multiplierReg_t;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_t;

    modport master (
        output multiplicand_in, multiplicand_in_t, multiplier_in, multiplier_in_t,
        output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
        input  multiplierReg, multiplierReg_t, product, product_t
    );

    modport slave (
        input  multiplicand_in, multiplicand_in_t, multiplier_in, multiplier_in_t,
        input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
        output multiplierReg, multiplierReg_t, product, product_t
    );
endinterface

// File: rtl/multiplier_datapath_taint_track.sv
// multiplier_datapath_taint_track: shift-add multiplier datapath with per-bit shadow taint
module multiplier_datapath_taint_track #(
    parameter int WIDTH = 4
) (
    input logic                              clk,
    input logic                              rst,
    multiplier_datapath_taint_track_if.slave bus
);
    logic [WIDTH-1:0]   md, md_t, mr, mr_t;
    logic [2*WIDTH:0]   rs, rs_t, rs_n, rs_t_base, rs_t_n;
    logic [WIDTH:0]     sum, sum_t;
    logic [WIDTH-1:0]   m, neg_m;

    // next RS value/taint: clear > load > shift, then control-taint overlays
    always_comb begin
        sum       = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
        m         = rs_t[2*WIDTH-1:WIDTH] | md_t;
        neg_m     = ~m + WIDTH'(1);
        sum_t     = {|m, m | neg_m};
        rs_n      = bus.rsclear ? '0 :
                    bus.rsload  ? {sum, rs[WIDTH-1:0]} :
                    bus.rsshr   ? rs >> 1 : rs;
        rs_t_base = bus.rsclear ? {(2*WIDTH+1){bus.rsclear_t}} :
                    bus.rsload  ? {sum_t, rs_t[WIDTH-1:0]} :
                    bus.rsshr   ? rs_t >> 1 : rs_t;
        rs_t_n    = (bus.rsclear_t || bus.rsshr_t) ? '1 :
                    bus.rsload_t ? {{(WIDTH+1){1'b1}}, rs_t_base[WIDTH-1:0]} : rs_t_base;
    end

    // register update; reset overrides every strobe and clears all taint
    always_ff @(posedge clk) begin
        if (rst) begin
            md   <= '0;
            md_t <= '0;
            mr   <= '0;
            mr_t <= '0;
            rs   <= '0;
            rs_t <= '0;
        end else begin
            md   <= bus.mdld ? bus.multiplicand_in : md;
            md_t <= bus.mdld_t ? '1 : bus.mdld ? bus.multiplicand_in_t : md_t;
            mr   <= bus.mrld ? bus.multiplier_in : mr;
            mr_t <= bus.mrld_t ? '1 : bus.mrld ? bus.multiplier_in_t : mr_t;
            rs   <= rs_n;
            rs_t <= rs_t_n;
        end
    end

    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = mr_t;
    assign bus.product         = rs[2*WIDTH-1:0];
    assign bus.product_t       = rs_t[2*WIDTH-1:0];
endmodule

// File: tb/tb_multiplier_datapath_taint_track.sv
// tb_multiplier_datapath_taint_track: directed controller sequences checked against a behavioural model
module tb_multiplier_datapath_taint_track;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;

    multiplier_datapath_taint_track_if #(.WIDTH(4)) bus ();

    multiplier_datapath_taint_track #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state
    logic       m_ok = 1'b0;
    logic [3:0] m_md, m_md_t, m_mr, m_mr_t;
    logic [8:0] m_rs, m_rs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] model_rs(input logic [8:0] rs, input logic [8:0] rt,
                                            input logic [3:0] md, input logic [3:0] mdt,
                                            input logic clr, input logic clr_t,
                                            input logic ld, input logic ld_t,
                                            input logic sh, input logic sh_t);
        logic [8:0] v, t;
        logic any;
        int hi;
        v = rs;
        t = rt;
        if (clr) begin
            v = '0;
            t = {9{clr_t}};
        end else if (ld) begin
            hi = int'(rs[7:4]) + int'(md);
            v = {hi[4:0], rs[3:0]};
            any = 1'b0;
            for (int j = 0; j < 4; j++) begin
                any = any | rt[4+j] | mdt[j];
                t[4+j] = any;
            end
            t[8] = any;
        end else if (sh) begin
            v = rs / 2;
            t = rt / 2;
        end
        if (clr_t || sh_t) t = '1;
        if (ld_t) t[8:4] = 5'h1F;
        return {v, t};
    endfunction

    // model update at each active edge
    always @(posedge clk) begin
        if (rst) begin
            m_ok   <= 1'b1;
            m_md   <= '0;
            m_md_t <= '0;
            m_mr   <= '0;
            m_mr_t <= '0;
            m_rs   <= '0;
            m_rs_t <= '0;
        end else begin
            m_md   <= bus.mdld ? bus.multiplicand_in : m_md;
            m_md_t <= bus.mdld_t ? 4'hF : bus.mdld ? bus.multiplicand_in_t : m_md_t;
            m_mr   <= bus.mrld ? bus.multiplier_in : m_mr;
            m_mr_t <= bus.mrld_t ? 4'hF : bus.mrld ? bus.multiplier_in_t : m_mr_t;
            {m_rs, m_rs_t} <= model_rs(m_rs, m_rs_t, m_md, m_md_t,
                                       bus.rsclear, bus.rsclear_t, bus.rsload, bus.rsload_t,
                                       bus.rsshr, bus.rsshr_t);
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ok) begin
            check("product", 32'(bus.product), 32'(m_rs[7:0]));
            check("product_t", 32'(bus.product_t), 32'(m_rs_t[7:0]));
            check("multiplierReg", 32'(bus.multiplierReg), 32'(m_mr));
            check("multiplierReg_t", 32'(bus.multiplierReg_t), 32'(m_mr_t));
        end
    end

    // one cycle of strobes {mdld, mrld, rsclear, rsload, rsshr, rsload_t, rsshr_t}
    task automatic cyc(input logic [6:0] s);
        @(negedge clk);
        {bus.mdld, bus.mrld, bus.rsclear, bus.rsload, bus.rsshr, bus.rsload_t, bus.rsshr_t} = s;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] at, input logic [3:0] b,
                       input logic [3:0] bt, input logic taint_last);
        bus.multiplicand_in   = a;
        bus.multiplicand_in_t = at;
        bus.multiplier_in     = b;
        bus.multiplier_in_t   = bt;
        cyc(7'b1100000);
        cyc(7'b0010000);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) cyc(7'b0001000);
            cyc({6'b000010, (i == 3) && taint_last});
        end
        cyc(7'b0000000);
    endtask

    initial begin
        bus.multiplicand_in = '0; bus.multiplicand_in_t = '0;
        bus.multiplier_in = '0;   bus.multiplier_in_t = '0;
        bus.mdld = 0; bus.mdld_t = 0; bus.mrld = 0; bus.mrld_t = 0;
        bus.rsclear = 0; bus.rsclear_t = 0; bus.rsload = 0; bus.rsload_t = 0;
        bus.rsshr = 0; bus.rsshr_t = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset product", 32'(bus.product), 32'h0);
        check("reset product_t", 32'(bus.product_t), 32'h0);
        run(4'd13, 4'h0, 4'd11, 4'h0, 1'b0);
        check("13x11 product", 32'(bus.product), 32'h8F);
        check("13x11 product_t", 32'(bus.product_t), 32'h00);
        check("13x11 mr", 32'(bus.multiplierReg), 32'hB);
        cyc(7'b0000010);
        cyc(7'b0000000);
        check("rsload_t product", 32'(bus.product), 32'h8F);
        check("rsload_t product_t", 32'(bus.product_t), 32'hF0);
        run(4'd15, 4'h0, 4'd15, 4'h0, 1'b0);
        check("15x15 product", 32'(bus.product), 32'hE1);
        check("15x15 product_t", 32'(bus.product_t), 32'h00);
        run(4'd13, 4'b0001, 4'b0001, 4'h0, 1'b0);
        check("taint md product", 32'(bus.product), 32'h0D);
        check("taint md product_t", 32'(bus.product_t), 32'h1F);
        run(4'd13, 4'h0, 4'd11, 4'h0, 1'b1);
        check("rsshr_t product", 32'(bus.product), 32'h8F);
        check("rsshr_t product_t", 32'(bus.product_t), 32'hFF);
        bus.multiplier_in = 4'd15;
        bus.multiplicand_in_t = 4'hF;
        cyc(7'b1100000);
        cyc(7'b0010000);
        cyc(7'b0001000);
        cyc(7'b0000100);
        cyc(7'b0001000);
        rst = 1'b1;
        cyc(7'b0011000);
        cyc(7'b0000000);
        rst = 1'b0;
        check("mid reset product", 32'(bus.product), 32'h0);
        check("mid reset product_t", 32'(bus.product_t), 32'h0);
        check("mid reset mr", 32'(bus.multiplierReg), 32'h0);
        bus.multiplicand_in_t = 4'h0;
        cyc(7'b1000000);
        cyc(7'b0001000);
        cyc(7'b0000000);
        check("reload product", 32'(bus.product), 32'hD0);
        cyc(7'b0011100);
        cyc(7'b0000000);
        check("clear wins product", 32'(bus.product), 32'h0);
        check("clear wins product_t", 32'(bus.product_t), 32'h0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
